noc_net_iface: RTL and testbench
================================

NOC_NET_IFACE -- requirements
Module: noc_net_iface

Interface
REQ-001 Parameter CREDITS, default 8, SHALL set the initial and maximum credit count, equal to the router local-input buffer slots.
REQ-002 Parameter RXDEPTH, default 4, SHALL set the receive FIFO depth; it SHALL be a power of 2.
REQ-003 clk  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 node_addr  in  4  SHALL be this node's mesh address.
REQ-006 core_valid  in  1 / core_ready  out  1  SHALL form the core transmit handshake.
REQ-007 core_dest  in  4 / core_data  in  48  SHALL be the transmit destination and payload.
REQ-008 tx_flit  out  64 / tx_valid  out  1  SHALL carry the flit to the router local input port.
REQ-009 credit_ret  in  1  SHALL be a one-cycle pulse from the router returning one buffer slot.
REQ-010 rx_flit  in  64 / rx_valid  in  1  SHALL carry the flit from the router local output port.
REQ-011 core_rx_valid  out  1 / core_rx_ready  in  1  SHALL form the core receive handshake.
REQ-012 core_rx_data  out  48 / core_rx_src  out  4 / core_rx_seq  out  8  SHALL give the head received flit's fields.
REQ-013 err_misroute, err_overflow, err_credit  out  1 each  SHALL be sticky error flags.

Function
REQ-014 The flit format SHALL be: [3:0] dest, [7:4] src, [15:8] seq, [63:16] payload.
REQ-015 The transmit FSM SHALL have two states: IDLE and SEND.
REQ-016 core_ready SHALL be 1 only in IDLE.
REQ-017 In IDLE, core_valid=1 SHALL latch {core_data, seq_cnt, node_addr, core_dest} into a hold register and move the FSM to SEND.
REQ-018 In SEND with credits>0, tx_valid SHALL be 1 for exactly that cycle with tx_flit=hold; seq_cnt and credits SHALL be updated at the following edge; the FSM SHALL return to IDLE.
REQ-019 In SEND with credits=0, tx_valid SHALL be 0 and the FSM SHALL stay in SEND, holding tx_flit stable, until a credit arrives.
REQ-020 The minimum accept-to-send latency SHALL be 1 cycle: handshake at edge N gives tx_valid high in cycle N+1; the maximum throughput SHALL be one flit per 2 cycles.
REQ-021 seq_cnt SHALL be 8-bit and SHALL wrap from 255 to 0.
REQ-022 credits SHALL be a counter of width clog2(CREDITS+1).
REQ-023 On a send and a credit_ret in the same cycle, credits SHALL be unchanged.
REQ-024 A credit_ret while credits=CREDITS with no send SHALL be ignored and SHALL set err_credit.
REQ-025 core_dest==node_addr SHALL be legal and SHALL be sent normally.
REQ-026 When tx_valid=0, tx_flit SHALL be 64'h0.
REQ-027 On rx_valid=1 with rx_flit[3:0]!=node_addr, the flit SHALL be dropped and err_misroute set.
REQ-028 On rx_valid=1 with a matching address, the flit SHALL be pushed to the receive FIFO.
REQ-029 When the FIFO is full with no pop in the same cycle, the incoming flit SHALL be dropped and err_overflow set.
REQ-030 When the FIFO is full and a pop and a push occur in the same cycle, both SHALL succeed.
REQ-031 core_rx_valid SHALL equal FIFO not-empty; data, src and seq SHALL come from the head entry; a pop SHALL occur when core_rx_valid and core_rx_ready are both 1.
REQ-032 The receive latency SHALL be 1 cycle: rx_valid at edge N gives core_rx_valid in cycle N+1 if the FIFO was empty.
REQ-033 The FIFO pointers SHALL be clog2(RXDEPTH)+1 bits with wrap-bit full/empty detection.
REQ-034 When core_rx_valid=0, core_rx_data, core_rx_src and core_rx_seq SHALL be 0.
REQ-035 Receive and transmit paths SHALL operate independently and concurrently.

Reset
REQ-036 rst=0 SHALL immediately force: FSM=IDLE, credits=CREDITS, seq_cnt=0, FIFO empty, all error flags 0, tx_valid=0, tx_flit=0, core_rx_valid=0, core_ready=0 while rst=0.
REQ-037 A reset in SEND SHALL discard the held flit, which SHALL never be emitted.
REQ-038 Following rst deassertion, core_ready SHALL be 1 in the first cycle.
REQ-039 Error flags SHALL clear only on reset.

Verification
REQ-040 The bench SHALL cover: node_addr=5, send dest=9 data=48'hABCDEF012345 -> one cycle later tx_valid=1, tx_flit=64'hABCDEF012345_00_5_9, credits=7.
REQ-041 The bench SHALL cover: 8 back-to-back sends with no credit_ret -> the 9th is held in SEND with tx_valid=0; one credit_ret pulse -> the 9th is emitted the next cycle.
REQ-042 The bench SHALL cover: a send coincident with credit_ret -> credits unchanged; credit_ret at credits=8 -> err_credit=1 and credits stay 8.
REQ-043 The bench SHALL cover: rx_flit[3:0]=3 with node_addr=5 -> no push and err_misroute=1; rx_flit[3:0]=5 -> core_rx_valid=1 next cycle with the correct fields.
REQ-044 The bench SHALL cover: 5 matching flits with core_rx_ready=0 -> 4 stored, 5th dropped, err_overflow=1; with full FIFO, push plus pop in one cycle -> both succeed and FIFO stays full.
REQ-045 The bench SHALL cover: 256 sends -> seq wraps 255 to 0; rst asserted mid-SEND -> no tx_valid, all outputs at reset values.

Source files
------------

// File: rtl/noc_net_iface.sv
// noc_net_iface -- network interface between a core and the local port of a
// mesh router. The transmit path uses credit-based flow control. The receive
// path has a small FIFO that checks the destination address of each flit.
//
// Flit layout: [3:0] dest, [7:4] src, [15:8] seq, [63:16] payload.
//
// Ports
//   clk, rst                        clock; asynchronous active-low reset
//   node_addr[3:0]                  this node's mesh address
//   core_valid/core_ready           core transmit handshake
//   core_dest[3:0], core_data[47:0] transmit destination and payload
//   tx_flit[63:0], tx_valid         flit to the router local input port
//   credit_ret                      one buffer slot returned by the router
//   rx_flit[63:0], rx_valid         flit from the router local output port
//   core_rx_valid/core_rx_ready     core receive handshake
//   core_rx_data/src/seq            fields of the head received flit
//   err_misroute/overflow/credit    sticky error flags, cleared only by reset
//
// Transmit FSM
//   state | meaning
//   IDLE  | ready to accept a flit from the core
//   SEND  | flit held; emitted in the first cycle that has a credit
module noc_net_iface #(
  parameter int CREDITS = 8,
  parameter int RXDEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  node_addr,
  input  logic        core_valid,
  output logic        core_ready,
  input  logic [3:0]  core_dest,
  input  logic [47:0] core_data,
  output logic [63:0] tx_flit,
  output logic        tx_valid,
  input  logic        credit_ret,
  input  logic [63:0] rx_flit,
  input  logic        rx_valid,
  output logic        core_rx_valid,
  input  logic        core_rx_ready,
  output logic [47:0] core_rx_data,
  output logic [3:0]  core_rx_src,
  output logic [7:0]  core_rx_seq,
  output logic        err_misroute,
  output logic        err_overflow,
  output logic        err_credit
);

  localparam int CW = $clog2(CREDITS + 1);
  localparam int AW = $clog2(RXDEPTH);
  localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);
  localparam logic [CW-1:0] CRED_ONE = CW'(1);
  localparam logic [AW:0]   PTR_ONE  = (AW + 1)'(1);

  typedef enum logic {IDLE, SEND} tx_state_t;

  tx_state_t       state, state_nxt;
  logic [63:0]     hold;
  logic [7:0]      seq_cnt;
  logic [CW-1:0]   credits;
  logic            accept, send;

  // ---------------- transmit ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // core_ready is gated with rst so it reads 0 for the whole time reset is held.
  always_comb begin
    state_nxt  = state;
    core_ready = 1'b0;
    tx_valid   = 1'b0;
    tx_flit    = 64'h0;
    accept     = 1'b0;
    send       = 1'b0;
    case (state)
      IDLE: begin
        core_ready = rst;
        if (core_valid) begin
          accept    = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (credits != '0) begin
          send      = 1'b1;
          tx_valid  = 1'b1;
          tx_flit   = hold;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold    <= 64'h0;
      seq_cnt <= 8'h0;
    end else begin
      if (accept) hold <= {core_data, seq_cnt, node_addr, core_dest};
      if (send)   seq_cnt <= seq_cnt + 8'h1;
    end
  end

  // A send and a returned credit in the same cycle cancel out. A credit
  // returned while the counter is already full is dropped and flagged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credits    <= CRED_MAX;
      err_credit <= 1'b0;
    end else if (send && !credit_ret) begin
      credits <= credits - CRED_ONE;
    end else if (!send && credit_ret) begin
      if (credits == CRED_MAX) err_credit <= 1'b1;
      else                     credits    <= credits + CRED_ONE;
    end
  end

  // ---------------- receive ----------------
  logic [59:0] rx_mem [RXDEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        rx_empty, rx_full, rx_match, rx_push, rx_pop;
  logic [59:0] rx_head;

  assign rx_empty = (wr_ptr == rd_ptr);
  assign rx_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rx_match = rx_valid && (rx_flit[3:0] == node_addr);
  assign rx_pop   = !rx_empty && core_rx_ready;
  // A full FIFO still accepts a flit when the head leaves in the same cycle.
  assign rx_push  = rx_match && (!rx_full || rx_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      err_misroute <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      if (rx_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (rx_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (rx_valid && (rx_flit[3:0] != node_addr)) err_misroute <= 1'b1;
      if (rx_match && rx_full && !rx_pop)          err_overflow <= 1'b1;
    end
  end

  // Only payload, seq and src are stored; dest is known to equal node_addr.
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[wr_ptr[AW-1:0]] <= {rx_flit[63:16], rx_flit[15:8], rx_flit[7:4]};
  end

  assign rx_head       = rx_mem[rd_ptr[AW-1:0]];
  assign core_rx_valid = !rx_empty;
  assign core_rx_data  = rx_empty ? 48'h0 : rx_head[59:12];
  assign core_rx_seq   = rx_empty ? 8'h0  : rx_head[11:4];
  assign core_rx_src   = rx_empty ? 4'h0  : rx_head[3:0];

endmodule

// File: tb/tb_noc_net_iface.sv
// tb_noc_net_iface -- directed bench for noc_net_iface with node_addr=5.
// Inputs are driven 1 ns after each rising edge. Outputs are checked at the
// same point, once the registered state and the new inputs have settled.
module tb_noc_net_iface;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  node_addr;
  logic        core_valid;
  logic        core_ready;
  logic [3:0]  core_dest;
  logic [47:0] core_data;
  logic [63:0] tx_flit;
  logic        tx_valid;
  logic        credit_ret;
  logic [63:0] rx_flit;
  logic        rx_valid;
  logic        core_rx_valid;
  logic        core_rx_ready;
  logic [47:0] core_rx_data;
  logic [3:0]  core_rx_src;
  logic [7:0]  core_rx_seq;
  logic        err_misroute;
  logic        err_overflow;
  logic        err_credit;

  int n_checks = 0;
  int n_pass   = 0;

  noc_net_iface #(.CREDITS(8), .RXDEPTH(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .node_addr     (node_addr),
    .core_valid    (core_valid),
    .core_ready    (core_ready),
    .core_dest     (core_dest),
    .core_data     (core_data),
    .tx_flit       (tx_flit),
    .tx_valid      (tx_valid),
    .credit_ret    (credit_ret),
    .rx_flit       (rx_flit),
    .rx_valid      (rx_valid),
    .core_rx_valid (core_rx_valid),
    .core_rx_ready (core_rx_ready),
    .core_rx_data  (core_rx_data),
    .core_rx_src   (core_rx_src),
    .core_rx_seq   (core_rx_seq),
    .err_misroute  (err_misroute),
    .err_overflow  (err_overflow),
    .err_credit    (err_credit)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; node_addr = 4'd5;
    core_valid = 1'b0; core_dest = 4'd0; core_data = 48'h0;
    credit_ret = 1'b0; rx_flit = 64'h0; rx_valid = 1'b0; core_rx_ready = 1'b0;

    // ---- reset state ----
    step(); step();
    check("rst_core_ready", core_ready, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_flit", tx_flit, 0);
    check("rst_rx_valid", core_rx_valid, 0);
    check("rst_errs", {err_misroute, err_overflow, err_credit}, 0);
    check("rst_credits", dut.credits, 8);
    rst = 1'b1;
    #1;
    check("first_cycle_ready", core_ready, 1);

    // ---- single send ----
    step();
    core_valid = 1'b1; core_dest = 4'd9; core_data = 48'hABCDEF012345;
    step();
    core_valid = 1'b0;
    check("send1_valid", tx_valid, 1);
    check("send1_flit", tx_flit, 64'hABCDEF012345_00_5_9);
    check("send1_ready_low", core_ready, 0);
    step();
    check("send1_credits", dut.credits, 7);
    check("send1_idle_flit", tx_flit, 0);
    check("send1_ready", core_ready, 1);
    credit_ret = 1'b1;
    step();
    credit_ret = 1'b0;
    check("refill_credits", dut.credits, 8);

    // ---- credits exhausted: 8 sends, 9th held ----
    for (int i = 0; i < 8; i++) begin
      core_valid = 1'b1; core_dest = 4'(i); core_data = 48'(i);
      step();
      core_valid = 1'b0;
      check("b2b_valid", tx_valid, 1);
      step();
    end
    check("b2b_credits_zero", dut.credits, 0);
    core_valid = 1'b1; core_dest = 4'd2; core_data = 48'h99;
    step();
    core_valid = 1'b0;
    check("held_valid", tx_valid, 0);
    check("held_flit", tx_flit, 0);
    check("held_ready", core_ready, 0);
    step();
    check("held_valid2", tx_valid, 0);
    credit_ret = 1'b1;
    step();
    credit_ret = 1'b0;
    check("released_valid", tx_valid, 1);
    check("released_flit", tx_flit, {48'h99, 8'd9, 4'd5, 4'd2});
    step();
    check("released_credits", dut.credits, 0);

    // ---- send coincident with credit_ret, then overfull credit ----
    credit_ret = 1'b1;
    step(); step();
    credit_ret = 1'b0;
    check("two_credits", dut.credits, 2);
    core_valid = 1'b1; core_dest = 4'd1; core_data = 48'h1;
    step();
    core_valid = 1'b0;
    credit_ret = 1'b1;
    check("coinc_valid", tx_valid, 1);
    step();
    credit_ret = 1'b0;
    check("coinc_credits", dut.credits, 2);
    credit_ret = 1'b1;
    for (int i = 0; i < 6; i++) step();
    credit_ret = 1'b0;
    check("full_credits", dut.credits, 8);
    check("no_err_credit", err_credit, 0);
    credit_ret = 1'b1;
    step();
    credit_ret = 1'b0;
    check("err_credit_set", err_credit, 1);
    check("credits_stay_8", dut.credits, 8);
    step();
    check("err_credit_sticky", err_credit, 1);

    // ---- receive: misroute then a good flit ----
    rx_flit = {48'h111, 8'h22, 4'h7, 4'h3}; rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
    check("misroute_err", err_misroute, 1);
    check("misroute_nopush", core_rx_valid, 0);
    rx_flit = {48'hCAFE0000BEEF, 8'h42, 4'hA, 4'h5}; rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
    check("rx_valid", core_rx_valid, 1);
    check("rx_data", core_rx_data, 48'hCAFE0000BEEF);
    check("rx_src", core_rx_src, 4'hA);
    check("rx_seq", core_rx_seq, 8'h42);
    core_rx_ready = 1'b1;
    step();
    core_rx_ready = 1'b0;
    check("rx_popped", core_rx_valid, 0);
    check("rx_data_zero", core_rx_data, 0);

    // ---- receive overflow, push+pop while full ----
    for (int k = 1; k <= 5; k++) begin
      rx_flit = {48'(k), 8'(k), 4'h1, 4'h5}; rx_valid = 1'b1;
      step();
      if (k == 4) check("no_overflow_at_4", err_overflow, 0);
    end
    rx_valid = 1'b0;
    check("overflow_err", err_overflow, 1);
    check("ovf_head_seq", core_rx_seq, 1);
    rx_flit = {48'h6, 8'd6, 4'h1, 4'h5}; rx_valid = 1'b1; core_rx_ready = 1'b1;
    step();
    rx_valid = 1'b0;
    begin
      logic [7:0] exp_seq [4];
      exp_seq = '{8'd2, 8'd3, 8'd4, 8'd6};
      for (int i = 0; i < 4; i++) begin
        check("drain_valid", core_rx_valid, 1);
        check("drain_seq", core_rx_seq, exp_seq[i]);
        step();
      end
    end
    core_rx_ready = 1'b0;
    check("drain_empty", core_rx_valid, 0);
    check("overflow_sticky", err_overflow, 1);

    // ---- 256 sends: seq wraps (seq_cnt currently 11) ----
    for (int i = 0; i < 256; i++) begin
      core_valid = 1'b1; core_dest = 4'd3; core_data = 48'(i);
      step();
      core_valid = 1'b0;
      credit_ret = 1'b1;
      if (i == 244) check("seq_255", tx_flit[15:8], 8'd255);
      if (i == 245) check("seq_wrap_0", tx_flit[15:8], 8'd0);
      step();
      credit_ret = 1'b0;
    end
    check("wrap_credits", dut.credits, 8);

    // ---- reset while in SEND ----
    core_valid = 1'b1; core_dest = 4'd4; core_data = 48'h777;
    step();
    core_valid = 1'b0;
    check("pre_rst_seq", tx_flit, {48'h777, 8'd11, 4'd5, 4'd4});
    rst = 1'b0;
    #1;
    check("rst_mid_valid", tx_valid, 0);
    check("rst_mid_flit", tx_flit, 0);
    check("rst_mid_ready", core_ready, 0);
    step();
    check("rst_mid_credits", dut.credits, 8);
    check("rst_mid_errs", {err_misroute, err_overflow, err_credit}, 0);
    check("rst_mid_rxv", core_rx_valid, 0);
    rst = 1'b1;
    #1;
    check("post_rst_ready", core_ready, 1);
    step();
    check("held_discarded", tx_valid, 0);
    core_valid = 1'b1; core_dest = 4'd6; core_data = 48'h1234;
    step();
    core_valid = 1'b0;
    check("post_rst_flit", tx_flit, {48'h1234, 8'd0, 4'd5, 4'd6});
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
